// File: rtl/relay_pulse_sequencer_pkg.sv
// Shared types and default timing for the latching-relay coil sequencer.
package relay_pulse_sequencer_pkg;

  typedef enum logic [2:0] {
    INIT_PULSE,
    INIT_DEAD,
    IDLE,
    PULSE,
    DEAD
  } relay_fsm_t;

  // 10 ms coil drive and 5 ms recovery at a 125 MHz clock.
  localparam int RELAY_PULSE_CYCLES_125M = 1250000;
  localparam int RELAY_DEAD_CYCLES_125M  = 625000;

endpackage

// File: rtl/relay_interval_timer.sv
// Loadable down-counter shared by the coil-drive and recovery intervals.
module relay_interval_timer #(
  parameter int CNT_WIDTH = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/relay_pulse_sequencer.sv
// Pulses one latching-relay coil at a time through its H-bridge and tracks
// each relay's latched position; all relays are driven to input after reset.
module relay_pulse_sequencer
  import relay_pulse_sequencer_pkg::*;
#(
  parameter int NUM_RELAYS   = 4,
  parameter int PULSE_CYCLES = RELAY_PULSE_CYCLES_125M,
  parameter int DEAD_CYCLES  = RELAY_DEAD_CYCLES_125M,
  parameter int CNT_WIDTH    = 21,
  parameter int CH_WIDTH     = (NUM_RELAYS > 1) ? $clog2(NUM_RELAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CH_WIDTH-1:0]   req_channel,
  input  logic                  req_dir,
  output logic                  req_done,
  output logic                  req_err,
  output logic                  busy,
  output logic [NUM_RELAYS-1:0] relay_state,
  output logic [NUM_RELAYS-1:0] relay_a,
  output logic [NUM_RELAYS-1:0] relay_b
);

  localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEAD_LOAD  = CNT_WIDTH'(DEAD_CYCLES - 1);
  localparam logic [CH_WIDTH-1:0]  LAST_CH    = CH_WIDTH'(NUM_RELAYS - 1);

  relay_fsm_t            r_state, w_state;
  logic [CH_WIDTH-1:0]   r_ch, w_ch;
  logic                  r_dir, w_dir;
  logic [NUM_RELAYS-1:0] r_a, w_a, r_b, w_b, r_rs, w_rs;
  logic                  r_ready, r_done, w_done, r_err, w_err, r_busy;
  logic                  w_load, w_expired, w_req_oor, w_req_match;
  logic [CNT_WIDTH-1:0]  w_value;
  logic [NUM_RELAYS-1:0] w_sel_cur, w_sel_req;

  relay_interval_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .value  (w_value),
    .expired(w_expired)
  );

  assign w_sel_cur   = NUM_RELAYS'(1) << r_ch;
  assign w_sel_req   = NUM_RELAYS'(1) << req_channel;
  assign w_req_oor   = (int'(req_channel) >= NUM_RELAYS);
  assign w_req_match = ((|(r_rs & w_sel_req)) == req_dir);

  always_comb begin
    w_state = r_state;
    w_ch    = r_ch;
    w_dir   = r_dir;
    w_a     = r_a;
    w_b     = r_b;
    w_rs    = r_rs;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_load  = 1'b0;
    w_value = PULSE_LOAD;
    case (r_state)
      INIT_PULSE: begin
        // Coming out of reset the coil is still off: arm the timer and drive it.
        if (r_b == '0) begin
          w_load = 1'b1;
          w_b    = w_sel_cur;
        end else if (w_expired) begin
          w_state = INIT_DEAD;
          w_load  = 1'b1;
          w_value = DEAD_LOAD;
          w_b     = '0;
          w_rs    = r_rs & ~w_sel_cur;
        end
      end
      INIT_DEAD: begin
        if (w_expired) begin
          if (r_ch != LAST_CH) begin
            w_ch    = r_ch + 1'b1;
            w_state = INIT_PULSE;
            w_load  = 1'b1;
            w_b     = NUM_RELAYS'(1) << w_ch;
          end else begin
            w_state = IDLE;
          end
        end
      end
      IDLE: begin
        if (req_valid && r_ready) begin
          if (w_req_oor) begin
            w_err  = 1'b1;
            w_done = 1'b1;
          end else if (w_req_match) begin
            w_done = 1'b1;
          end else begin
            w_ch    = req_channel;
            w_dir   = req_dir;
            w_state = PULSE;
            w_load  = 1'b1;
            if (req_dir) w_a = w_sel_req;
            else         w_b = w_sel_req;
          end
        end
      end
      PULSE: begin
        if (w_expired) begin
          w_state = DEAD;
          w_load  = 1'b1;
          w_value = DEAD_LOAD;
          w_a     = '0;
          w_b     = '0;
          w_rs    = r_dir ? (r_rs | w_sel_cur) : (r_rs & ~w_sel_cur);
        end
      end
      DEAD: begin
        if (w_expired) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end
      end
      default: begin
        w_state = INIT_PULSE;
        w_a     = '0;
        w_b     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT_PULSE;
      r_ch    <= '0;
      r_dir   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rs    <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_ch    <= w_ch;
      r_dir   <= w_dir;
      r_a     <= w_a;
      r_b     <= w_b;
      r_rs    <= w_rs;
      r_ready <= (w_state == IDLE);
      r_done  <= w_done;
      r_err   <= w_err;
      r_busy  <= (w_state != IDLE);
    end
  end

  assign req_ready   = r_ready;
  assign req_done    = r_done;
  assign req_err     = r_err;
  assign busy        = r_busy;
  assign relay_state = r_rs;
  assign relay_a     = r_a;
  assign relay_b     = r_b;

endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Directed bench for relay_pulse_sequencer: a 4-relay and a 3-relay instance
// with short pulse/dead intervals so every cycle can be checked.
module tb_relay_pulse_sequencer;

  localparam int P = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic       rst_n, v, dir, ready, done, err, busy;
  logic [1:0] ch;
  logic [3:0] rs, a, b, exp_b, exp_a;

  logic       rst3_n, v3, dir3, ready3, done3, err3, busy3;
  logic [1:0] ch3;
  logic [2:0] rs3, a3, b3;

  relay_pulse_sequencer #(
    .NUM_RELAYS(4), .PULSE_CYCLES(P), .DEAD_CYCLES(D), .CNT_WIDTH(4), .CH_WIDTH(2)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(ready),
    .req_channel(ch), .req_dir(dir), .req_done(done), .req_err(err),
    .busy(busy), .relay_state(rs), .relay_a(a), .relay_b(b)
  );

  relay_pulse_sequencer #(
    .NUM_RELAYS(3), .PULSE_CYCLES(P), .DEAD_CYCLES(D), .CNT_WIDTH(4), .CH_WIDTH(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(ready3),
    .req_channel(ch3), .req_dir(dir3), .req_done(done3), .req_err(err3),
    .busy(busy3), .relay_state(rs3), .relay_a(a3), .relay_b(b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Coil invariant on both instances, every cycle.
  always @(negedge clk) begin
    chk("coil_onehot4", 32'(((a & b) == 4'b0) && ($countones(a | b) <= 1)), 32'd1);
    chk("coil_onehot3", 32'(((a3 & b3) == 3'b0) && ($countones(a3 | b3) <= 1)), 32'd1);
  end

  task automatic check_init();
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      exp_b = (i < 48 && (i % 12) < 8) ? 4'(1 << (i / 12)) : 4'b0;
      chk("init_b", 32'(b), 32'(exp_b));
      chk("init_a", 32'(a), 32'(4'b0));
      chk("init_ready", 32'(ready), 32'(i == 48));
    end
    chk("init_state", 32'(rs), 32'(4'b0));
    chk("init_busy", 32'(busy), 32'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    v = 1'b0; ch = 2'd0; dir = 1'b0;
    v3 = 1'b0; ch3 = 2'd0; dir3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(a), 32'(4'b0));
    chk("rst_b", 32'(b), 32'(4'b0));
    chk("rst_state", 32'(rs), 32'(4'b0));
    chk("rst_ready", 32'(ready), 32'(1'b0));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_err", 32'(err), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b1; rst3_n = 1'b1;
    check_init();

    // Set relay 2: coil for 8 cycles, state visible in first dead cycle, done at +13.
    v = 1'b1; ch = 2'd2; dir = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j == 0) v = 1'b0;
      exp_a = (j < 8) ? 4'b0100 : 4'b0000;
      chk("set2_a", 32'(a), 32'(exp_a));
      chk("set2_b", 32'(b), 32'(4'b0));
      chk("set2_done", 32'(done), 32'(j == 12));
      chk("set2_ready", 32'(ready), 32'(j == 12));
      if (j == 7) chk("set2_state_pre", 32'(rs), 32'(4'b0000));
      if (j == 8) chk("set2_state_post", 32'(rs), 32'(4'b0100));
    end

    // Same request again: no pulse, done next cycle, ready stays high.
    v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    chk("noop_done", 32'(done), 32'(1'b1));
    chk("noop_ready", 32'(ready), 32'(1'b1));
    chk("noop_coil", 32'(a | b), 32'(4'b0));
    @(negedge clk);
    chk("noop_done_end", 32'(done), 32'(1'b0));
    chk("noop_ready_end", 32'(ready), 32'(1'b1));
    chk("noop_state", 32'(rs), 32'(4'b0100));

    // Back-to-back with valid held: ch0 then ch1.
    v = 1'b1; ch = 2'd0; dir = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j == 0) ch = 2'd1;
      exp_a = (j < 8) ? 4'b0001 : 4'b0000;
      chk("b2b0_a", 32'(a), 32'(exp_a));
      chk("b2b0_ready", 32'(ready), 32'(j == 12));
      chk("b2b0_done", 32'(done), 32'(j == 12));
    end
    chk("b2b0_state", 32'(rs), 32'(4'b0101));
    @(negedge clk);
    v = 1'b0;
    chk("b2b1_start_a", 32'(a), 32'(4'b0010));
    chk("b2b1_start_ready", 32'(ready), 32'(1'b0));
    for (int j = 1; j < 13; j++) begin
      @(negedge clk);
      exp_a = (j < 8) ? 4'b0010 : 4'b0000;
      chk("b2b1_a", 32'(a), 32'(exp_a));
      chk("b2b1_done", 32'(done), 32'(j == 12));
    end
    chk("b2b1_state", 32'(rs), 32'(4'b0111));

    // Reset during the third cycle of a pulse on relay 3.
    v = 1'b1; ch = 2'd3; dir = 1'b1;
    @(negedge clk);
    v = 1'b0;
    chk("mid_a0", 32'(a), 32'(4'b1000));
    repeat (2) @(negedge clk);
    chk("mid_a2", 32'(a), 32'(4'b1000));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", 32'(a), 32'(4'b0));
    chk("mid_rst_b", 32'(b), 32'(4'b0));
    chk("mid_rst_state", 32'(rs), 32'(4'b0));
    chk("mid_rst_busy", 32'(busy), 32'(1'b1));
    chk("mid_rst_ready", 32'(ready), 32'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_init();

    // Three-relay instance: set relay 1, then an out-of-range request.
    chk("n3_ready", 32'(ready3), 32'(1'b1));
    chk("n3_busy", 32'(busy3), 32'(1'b0));
    chk("n3_state0", 32'(rs3), 32'(3'b000));
    v3 = 1'b1; ch3 = 2'd1; dir3 = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j == 0) v3 = 1'b0;
      chk("n3_set1_a", 32'(a3), 32'((j < 8) ? 3'b010 : 3'b000));
      chk("n3_set1_done", 32'(done3), 32'(j == 12));
    end
    chk("n3_state1", 32'(rs3), 32'(3'b010));
    v3 = 1'b1; ch3 = 2'd3; dir3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("n3_oor_err", 32'(err3), 32'(1'b1));
    chk("n3_oor_done", 32'(done3), 32'(1'b1));
    chk("n3_oor_ready", 32'(ready3), 32'(1'b1));
    chk("n3_oor_coil", 32'(a3 | b3), 32'(3'b000));
    chk("n3_oor_state", 32'(rs3), 32'(3'b010));
    @(negedge clk);
    chk("n3_oor_err_end", 32'(err3), 32'(1'b0));
    chk("n3_oor_done_end", 32'(done3), 32'(1'b0));
    chk("n3_oor_coil_end", 32'(a3 | b3), 32'(3'b000));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
